mem_port_arbiter: RTL and testbench

- Shares one external memory port between the pipeline's instruction-fetch requester (IF) and data requester (MEM stage).
- Sequences each access as request, wait-for-ack, then a registered response; drives the active-low ack handshake style the core already uses.
- Data side has priority; a starvation counter guarantees fetch progress.
- A watchdog aborts hung accesses and flags a bus error.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the data stage.
// Data has priority, a starvation counter forces fetch through, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack_n,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack_n,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_write,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack_n,
   output logic [1:0]  grant,
   output logic        bus_err
);

   // state | meaning
   // IDLE  | port free, arbitrating every cycle
   // GNT_I | fetch owns the port, waiting for m_ack_n
   // GNT_D | data owns the port, waiting for m_ack_n

   typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] FETCH_SIZE = 2'b10;

   state_t      state, state_nxt;
   logic [3:0]  starve_cnt, starve_nxt;
   logic [7:0]  tmo_cnt, tmo_nxt;
   logic        i_elig, d_elig, pick_i, pick_d, done, abort;
   logic        m_req_nxt, m_write_nxt, i_ack_n_nxt, d_ack_n_nxt, bus_err_nxt;
   logic [1:0]  m_size_nxt, grant_nxt;
   logic [31:0] m_addr_nxt, m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;

   // A requester with its ack pulse showing is finishing; its req is treated as consumed.
   always_comb begin
      i_elig = i_req && i_ack_n;
      d_elig = d_req && d_ack_n;
      pick_i = 1'b0;
      pick_d = 1'b0;
      if (i_elig && d_elig) begin
         if (starve_cnt >= STARVE_MAX) pick_i = 1'b1;
         else                          pick_d = 1'b1;
      end else begin
         pick_i = i_elig;
         pick_d = d_elig;
      end
      done  = (state != IDLE) && !m_ack_n;
      abort = (state != IDLE) && m_ack_n && (tmo_cnt == TMO_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         m_req      <= 1'b0;
         m_write    <= 1'b0;
         m_size     <= '0;
         m_addr     <= '0;
         m_wdata    <= '0;
         i_ack_n    <= 1'b1;
         d_ack_n    <= 1'b1;
         i_rdata    <= '0;
         d_rdata    <= '0;
         grant      <= '0;
         bus_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         tmo_cnt    <= tmo_nxt;
         m_req      <= m_req_nxt;
         m_write    <= m_write_nxt;
         m_size     <= m_size_nxt;
         m_addr     <= m_addr_nxt;
         m_wdata    <= m_wdata_nxt;
         i_ack_n    <= i_ack_n_nxt;
         d_ack_n    <= d_ack_n_nxt;
         i_rdata    <= i_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
         grant      <= grant_nxt;
         bus_err    <= bus_err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (pick_d)      state_nxt = GNT_D;
            else if (pick_i) state_nxt = GNT_I;
         end
         GNT_I, GNT_D: begin
            if (done || abort) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      starve_nxt  = starve_cnt;
      tmo_nxt     = tmo_cnt;
      m_req_nxt   = m_req;
      m_write_nxt = m_write;
      m_size_nxt  = m_size;
      m_addr_nxt  = m_addr;
      m_wdata_nxt = m_wdata;
      i_ack_n_nxt = 1'b1;
      d_ack_n_nxt = 1'b1;
      i_rdata_nxt = i_rdata;
      d_rdata_nxt = d_rdata;
      grant_nxt   = grant;
      bus_err_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_d) begin
               m_req_nxt   = 1'b1;
               m_write_nxt = d_write;
               m_size_nxt  = d_size;
               m_addr_nxt  = d_addr;
               m_wdata_nxt = d_wdata;
               grant_nxt   = 2'b10;
               tmo_nxt     = '0;
               if (i_elig && (starve_cnt < STARVE_MAX)) starve_nxt = starve_cnt + 4'd1;
            end else if (pick_i) begin
               m_req_nxt   = 1'b1;
               m_write_nxt = 1'b0;
               m_size_nxt  = FETCH_SIZE;
               m_addr_nxt  = i_addr;
               grant_nxt   = 2'b01;
               tmo_nxt     = '0;
               starve_nxt  = '0;
            end
         end
         GNT_I, GNT_D: begin
            if (done || abort) begin
               m_req_nxt   = 1'b0;
               m_write_nxt = 1'b0;
               grant_nxt   = 2'b00;
               bus_err_nxt = abort;
               if (state == GNT_I) begin
                  i_ack_n_nxt = 1'b0;
                  i_rdata_nxt = done ? m_rdata : 32'h0;
               end else begin
                  d_ack_n_nxt = 1'b0;
                  // Stores leave the last load data in place.
                  if (!m_write) d_rdata_nxt = done ? m_rdata : 32'h0;
               end
            end else begin
               tmo_nxt = tmo_cnt + 8'd1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, starvation forcing, wait states, timeout, reset.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack_n;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_write;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack_n;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_write;
   logic [1:0]  m_size;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack_n;
   logic [1:0]  grant;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack_n(i_ack_n), .i_rdata(i_rdata),
      .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack_n(d_ack_n), .d_rdata(d_rdata),
      .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
      .grant(grant), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_write = 1'b0;
      d_size = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;
      step(); step();
      chk("rst_m_req", 32'(m_req), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_i_ack_n", 32'(i_ack_n), 32'd1);
      chk("rst_d_ack_n", 32'(d_ack_n), 32'd1);
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_m_addr", m_addr, 32'h0);
      rst_n = 1'b1;
      step();

      // fetch only, ack in first grant cycle
      i_req = 1'b1; i_addr = 32'h100; m_ack_n = 1'b0; m_rdata = 32'h0050_0093;
      step();
      chk("f_m_req", 32'(m_req), 32'd1);
      chk("f_m_addr", m_addr, 32'h100);
      chk("f_m_write", 32'(m_write), 32'd0);
      chk("f_grant", 32'(grant), 32'd1);
      step();
      chk("f_m_req_drop", 32'(m_req), 32'd0);
      chk("f_grant_idle", 32'(grant), 32'd0);
      chk("f_i_ack_n", 32'(i_ack_n), 32'd0);
      chk("f_i_rdata", i_rdata, 32'h0050_0093);
      i_req = 1'b0; m_ack_n = 1'b1;
      step();
      chk("f_ack_single", 32'(i_ack_n), 32'd1);
      chk("f_no_regrant", 32'(m_req), 32'd0);
      chk("f_addr_hold", m_addr, 32'h100);

      // simultaneous: data store first, then fetch
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
      m_ack_n = 1'b0; m_rdata = 32'h1111_1111;
      step();
      chk("s_grant_d", 32'(grant), 32'd2);
      chk("s_m_write", 32'(m_write), 32'd1);
      chk("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("s_m_addr", m_addr, 32'h2000);
      chk("s_m_size", 32'(m_size), 32'd2);
      step();
      chk("s_d_ack_n", 32'(d_ack_n), 32'd0);
      chk("s_d_rdata_kept", d_rdata, 32'h0);
      chk("s_i_ack_n_high", 32'(i_ack_n), 32'd1);
      d_req = 1'b0;
      step();
      chk("s_grant_i", 32'(grant), 32'd1);
      chk("s_i_m_addr", m_addr, 32'h200);
      chk("s_i_m_write", 32'(m_write), 32'd0);
      step();
      chk("s_i_ack_n", 32'(i_ack_n), 32'd0);
      chk("s_i_rdata", i_rdata, 32'h1111_1111);
      chk("s_d_rdata_still", d_rdata, 32'h0);
      i_req = 1'b0; m_ack_n = 1'b1;
      step();

      // starvation: fetch withdraws only during data ack cycles so both contend each round
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h3000; d_size = 2'd2;
      i_req = 1'b1; i_addr = 32'h400; m_ack_n = 1'b0; m_rdata = 32'h3333_0000;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("st_grant_d%0d", k), 32'(grant), 32'd2);
         step();
         chk($sformatf("st_d_ack%0d", k), 32'(d_ack_n), 32'd0);
         i_req = 1'b0;
         step();
         chk($sformatf("st_gap%0d", k), 32'(grant), 32'd0);
         i_req = 1'b1;
      end
      step();
      chk("st_forced_fetch", 32'(grant), 32'd1);
      chk("st_forced_addr", m_addr, 32'h400);
      step();
      chk("st_fetch_ack", 32'(i_ack_n), 32'd0);
      i_req = 1'b0;
      step();
      chk("st_data_after", 32'(grant), 32'd2);
      step();
      step();
      i_req = 1'b1;
      step();
      chk("st_cnt_cleared", 32'(grant), 32'd2);
      step();
      d_req = 1'b0;
      step();
      chk("st_tail_fetch", 32'(grant), 32'd1);
      step();
      i_req = 1'b0; m_ack_n = 1'b1;
      step();

      // load with 5 wait states
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h4000; d_size = 2'd1; m_rdata = 32'h0;
      step();
      chk("w_m_req", 32'(m_req), 32'd1);
      chk("w_m_addr", m_addr, 32'h4000);
      chk("w_m_size", 32'(m_size), 32'd1);
      for (int j = 0; j < 5; j++) begin
         step();
         chk($sformatf("w_req_hold%0d", j), 32'(m_req), 32'd1);
         chk($sformatf("w_addr_hold%0d", j), m_addr, 32'h4000);
         chk($sformatf("w_no_ack%0d", j), 32'(d_ack_n), 32'd1);
      end
      m_ack_n = 1'b0; m_rdata = 32'hCAFE_F00D;
      step();
      chk("w_d_ack_n", 32'(d_ack_n), 32'd0);
      chk("w_d_rdata", d_rdata, 32'hCAFE_F00D);
      chk("w_m_req_drop", 32'(m_req), 32'd0);
      chk("w_bus_err", 32'(bus_err), 32'd0);
      d_req = 1'b0; m_ack_n = 1'b1;
      step();
      chk("w_ack_once", 32'(d_ack_n), 32'd1);

      // timeout on a fetch, then a pending store served normally
      i_req = 1'b1; i_addr = 32'h500; m_rdata = 32'hFFFF_FFFF;
      step();
      chk("t_grant_i", 32'(grant), 32'd1);
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h6000; d_wdata = 32'h1234_5678; d_size = 2'd2;
      for (int j = 0; j < 7; j++) begin
         step();
         chk($sformatf("t_wait_req%0d", j), 32'(m_req), 32'd1);
         chk($sformatf("t_wait_err%0d", j), 32'(bus_err), 32'd0);
      end
      step();
      chk("t_i_ack_n", 32'(i_ack_n), 32'd0);
      chk("t_bus_err", 32'(bus_err), 32'd1);
      chk("t_i_rdata", i_rdata, 32'h0);
      chk("t_m_req_drop", 32'(m_req), 32'd0);
      i_req = 1'b0;
      step();
      chk("t_next_grant", 32'(grant), 32'd2);
      chk("t_next_write", 32'(m_write), 32'd1);
      chk("t_err_pulse", 32'(bus_err), 32'd0);
      m_ack_n = 1'b0;
      step();
      chk("t_next_ack", 32'(d_ack_n), 32'd0);
      chk("t_next_no_err", 32'(bus_err), 32'd0);
      d_req = 1'b0; m_ack_n = 1'b1;
      step();

      // asynchronous reset during a data grant
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h7000; d_wdata = 32'h7777_7777;
      step();
      chk("r_grant_d", 32'(grant), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("r_m_req_async", 32'(m_req), 32'd0);
      chk("r_grant_async", 32'(grant), 32'd0);
      chk("r_m_write_async", 32'(m_write), 32'd0);
      d_req = 1'b0; m_ack_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step();
         chk($sformatf("r_no_ack%0d", j), 32'(d_ack_n), 32'd1);
         chk($sformatf("r_idle%0d", j), 32'(grant), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
